// File: rtl/if_stage_if.sv
// if_stage_if: groups the fetch stage control inputs, instruction memory
// path and IF/ID outputs into one bundle.
//   slave  : the fetch stage (samples control and Inst_in, drives PC and IF/ID)
//   master : the environment (hazard unit, branch unit, instruction memory)
interface if_stage_if;
    logic        Stall;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic [31:0] Inst_in;
    logic [31:0] PC_out;
    logic [31:0] IF_ID_Inst;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic        Halted;
    logic [31:0] Fetch_Count;
    logic [15:0] Stall_Count;
    modport slave (
        input  Stall, Branch_taken, Branch_target, Inst_in,
        output PC_out, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid, Halted, Fetch_Count, Stall_Count
    );
    modport master (
        output Stall, Branch_taken, Branch_target, Inst_in,
        input  PC_out, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid, Halted, Fetch_Count, Stall_Count
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC register, IF/ID pipeline register,
// RUN/HALT control and fetch/stall counters.
//   clk, rst : clock and synchronous active-high reset
//   bus      : if_stage_if.slave carrying control inputs, instruction memory
//              address/data and the IF/ID, status and counter outputs
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'hFFFF_FFFF,
    parameter logic [7:0]  HALT_IDX = 8'hFF
) (
    input  logic         clk,
    input  logic         rst,
    if_stage_if.slave    bus
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, pc4_q, pc4_d, fc_q, fc_d;
    logic [15:0] sc_q, sc_d;
    logic        valid_q, valid_d;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fc_d    = fc_q;
        sc_d    = sc_q;
        if (bus.Branch_taken) begin
            pc_d    = {bus.Branch_target[31:2], 2'b00};
            inst_d  = BUBBLE;
            pc4_d   = '0;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (state_q == HALT) begin
            state_d = HALT;
        end else if (bus.Stall) begin
            sc_d = sc_q + {15'd0, sc_q != 16'hFFFF};
        end else if (pc_q[9:2] == HALT_IDX) begin
            // Reaching the halt word retires nothing: the PC parks on it.
            inst_d  = BUBBLE;
            pc4_d   = '0;
            valid_d = 1'b0;
            state_d = HALT;
        end else begin
            inst_d  = bus.Inst_in;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            fc_d    = fc_q + 32'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            inst_q  <= BUBBLE;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fc_q    <= '0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fc_q    <= fc_d;
            sc_q    <= sc_d;
        end
    end
    assign bus.PC_out      = pc_q;
    assign bus.IF_ID_Inst  = inst_q;
    assign bus.IF_ID_PC4   = pc4_q;
    assign bus.IF_ID_Valid = valid_q;
    assign bus.Halted      = state_q == HALT;
    assign bus.Fetch_Count = fc_q;
    assign bus.Stall_Count = sc_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scoreboard bench for if_stage.
module tb_if_stage;
    typedef struct {
        string       name;
        logic [31:0] pc, inst, pc4, fc;
        logic [15:0] sc;
        logic        v, h, ck4;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    if_stage_if bus();
    if_stage dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    localparam logic [31:0] BUB = 32'hFFFF_FFFF;
    localparam logic [31:0] IA = 32'h00A2_2820, IB = 32'h0021_0822, IC = 32'h0022_0820;
    function automatic exp_t mk(input string n, input logic [31:0] pc, inst, pc4, input logic v, h,
                                input logic [31:0] fc, input logic [15:0] sc, input logic ck4);
        exp_t e;
        e.name = n; e.pc = pc; e.inst = inst; e.pc4 = pc4; e.v = v; e.h = h;
        e.fc = fc; e.sc = sc; e.ck4 = ck4;
        return e;
    endfunction
    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask
    // Monitor: every output snapshot is registered, so sampling at the
    // falling edge sees the result of the preceding rising edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "pc", bus.PC_out, e.pc);
            chk(e.name, "inst", bus.IF_ID_Inst, e.inst);
            if (e.ck4) chk(e.name, "pc4", bus.IF_ID_PC4, e.pc4);
            chk(e.name, "valid", {31'd0, bus.IF_ID_Valid}, {31'd0, e.v});
            chk(e.name, "halted", {31'd0, bus.Halted}, {31'd0, e.h});
            chk(e.name, "fcnt", bus.Fetch_Count, e.fc);
            chk(e.name, "scnt", {16'd0, bus.Stall_Count}, {16'd0, e.sc});
        end
    end
    task automatic step(input logic r, s, b, input logic [31:0] tgt, inst, input exp_t e, input bit push);
        @(negedge clk);
        rst = r;
        bus.Stall = s;
        bus.Branch_taken = b;
        bus.Branch_target = tgt;
        bus.Inst_in = inst;
        @(posedge clk);
        if (push) q.push_back(e);
    endtask
    exp_t nx;
    initial begin
        bus.Stall = 1'b1;
        bus.Branch_taken = 1'b1;
        bus.Branch_target = 32'h40;
        bus.Inst_in = 32'h1234_5678;
        step(1, 1, 1, 32'h40, 32'h1, mk("rst0", 0, BUB, 0, 0, 0, 0, 0, 1), 1);
        // three free-running fetches
        step(0, 0, 0, 0, IA, mk("f0", 4, IA, 4, 1, 0, 1, 0, 1), 1);
        step(0, 0, 0, 0, IB, mk("f1", 8, IB, 8, 1, 0, 2, 0, 1), 1);
        step(0, 0, 0, 0, IC, mk("f2", 12, IC, 12, 1, 0, 3, 0, 1), 1);
        // reset then stall two cycles at PC=8
        step(1, 0, 0, 0, 0, mk("rst1", 0, BUB, 0, 0, 0, 0, 0, 1), 1);
        step(0, 0, 0, 0, IA, mk("g0", 4, IA, 4, 1, 0, 1, 0, 1), 1);
        step(0, 0, 0, 0, IB, mk("g1", 8, IB, 8, 1, 0, 2, 0, 1), 1);
        step(0, 1, 0, 0, IC, mk("st1", 8, IB, 8, 1, 0, 2, 1, 1), 1);
        step(0, 1, 0, 0, IC, mk("st2", 8, IB, 8, 1, 0, 2, 2, 1), 1);
        step(0, 0, 0, 0, IC, mk("rel", 12, IC, 12, 1, 0, 3, 2, 1), 1);
        step(0, 0, 0, 0, 32'hD, mk("f12", 16, 32'hD, 16, 1, 0, 4, 2, 1), 1);
        step(0, 0, 0, 0, 32'hE, mk("f16", 20, 32'hE, 20, 1, 0, 5, 2, 1), 1);
        step(0, 0, 0, 0, 32'hF, mk("f20", 24, 32'hF, 24, 1, 0, 6, 2, 1), 1);
        // branch beats stall, target low bits cleared
        step(0, 1, 1, 32'h9, 32'h77, mk("br9", 8, BUB, 0, 0, 0, 6, 2, 1), 1);
        step(0, 0, 0, 0, 32'h6, mk("f8", 12, 32'h6, 12, 1, 0, 7, 2, 1), 1);
        // a bubble-valued word is still a real instruction
        step(0, 0, 0, 0, BUB, mk("bubin", 16, BUB, 16, 1, 0, 8, 2, 1), 1);
        // halt at word index 0xFF
        step(0, 0, 1, 32'h3F8, 0, mk("br3f8", 32'h3F8, BUB, 0, 0, 0, 8, 2, 1), 1);
        step(0, 0, 0, 0, 32'hAB, mk("f3f8", 32'h3FC, 32'hAB, 32'h3FC, 1, 0, 9, 2, 1), 1);
        step(0, 0, 0, 0, 32'hCD, mk("halt", 32'h3FC, BUB, 0, 0, 1, 9, 2, 0), 1);
        step(0, 1, 0, 0, 32'hEF, mk("hhold", 32'h3FC, BUB, 0, 0, 1, 9, 2, 0), 1);
        step(0, 0, 1, 0, 0, mk("hbr", 0, BUB, 0, 0, 0, 9, 2, 1), 1);
        // reset overrides branch while halted
        step(0, 0, 1, 32'h3FC, 0, mk("br3fc", 32'h3FC, BUB, 0, 0, 0, 9, 2, 1), 1);
        step(0, 0, 0, 0, 32'h1, mk("halt2", 32'h3FC, BUB, 0, 0, 1, 9, 2, 0), 1);
        step(1, 1, 1, 32'h100, 0, mk("rsth", 0, BUB, 0, 0, 0, 0, 0, 1), 1);
        step(0, 0, 0, 0, 32'h55, mk("f0b", 4, 32'h55, 4, 1, 0, 1, 0, 1), 1);
        // stall counter saturation
        for (int i = 0; i < 65540; i++) step(0, 1, 0, 0, 32'h66, nx, 0);
        step(0, 1, 0, 0, 32'h66, mk("sat", 4, 32'h55, 4, 1, 0, 1, 16'hFFFF, 1), 1);
        step(1, 1, 0, 0, 0, mk("rsts", 0, BUB, 0, 0, 0, 0, 0, 1), 1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
